// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-add multiplier with valid/ready handshakes.
// Multiplies magnitudes R multiplier bits per clock, then applies the sign
// once on the final step. Signed or unsigned mode is chosen per operation.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands and mode presented
//   in_ready   block can accept an operation (IDLE only)
//   a, b       M-bit multiplicand / multiplier
//   is_signed  1: operands are two's complement, 0: unsigned
//   out_valid  product valid (DONE)
//   out_ready  consumer accepts product
//   product    2M-bit result, held until the next operation completes
//   busy       high while an operation is in RUN or DONE
module seq_mult_hs #(
    parameter int unsigned M = 12,
    parameter int unsigned R = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     a,
    input  logic [M-1:0]     b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*M-1:0]   product,
    output logic             busy
);

    localparam int unsigned Steps = M / R;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

    if (M < 2) begin : g_bad_m
        $error("seq_mult_hs: M must be at least 2");
    end
    if ((M % R) != 0) begin : g_bad_r
        $error("seq_mult_hs: R must divide M");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*M-1:0]  acc_q, acc_d;
    logic [M-1:0]    mcand_q, mcand_d;
    logic            neg_q, neg_d;
    logic [2*M-1:0]  product_q, product_d;

    // Magnitudes of the incoming operands. -2^(M-1) negates to itself, which
    // read as unsigned is exactly its magnitude.
    logic [M-1:0] a_abs, b_abs;
    always_comb begin
        a_abs = (is_signed && a[M-1]) ? -a : a;
        b_abs = (is_signed && b[M-1]) ? -b : b;
    end

    // One iteration: upper half plus mcand times the low R bits, M+R+1 wide,
    // then shift the whole accumulator right by R.
    logic [M+R:0]   hi_ext, mcand_ext, digit_ext, sum;
    logic [2*M-1:0] step, step_fixed;
    always_comb begin
        hi_ext     = {{(R+1){1'b0}}, acc_q[2*M-1:M]};
        mcand_ext  = {{(R+1){1'b0}}, mcand_q};
        digit_ext  = {{(M+1){1'b0}}, acc_q[R-1:0]};
        sum        = hi_ext + mcand_ext * digit_ext;
        step       = (2*M)'({sum, acc_q[M-1:0]} >> R);
        step_fixed = neg_q ? -step : step;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d = a_abs;
                    acc_d   = {{M{1'b0}}, b_abs};
                    neg_d   = is_signed & (a[M-1] ^ b[M-1]);
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = step;
                if (cnt_q == CntW'(Steps - 1)) begin
                    product_d = step_fixed;
                    cnt_d     = '0;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
module tb_seq_mult_hs;

    localparam int NI = 4;  // instance k uses R = k+1, M = 12

    logic        clk, rst;
    logic        in_valid [NI];
    logic        in_ready [NI];
    logic [11:0] a_in     [NI];
    logic [11:0] b_in     [NI];
    logic        is_signed[NI];
    logic        out_valid[NI];
    logic        out_ready[NI];
    logic [23:0] product  [NI];
    logic        busy     [NI];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        seq_mult_hs #(.M(12), .R(gi + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .a         (a_in[gi]),
            .b         (b_in[gi]),
            .is_signed (is_signed[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .product   (product[gi]),
            .busy      (busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [23:0] ref_prod(input logic [11:0] x, input logic [11:0] y,
                                             input logic s);
        longint xv, yv;
        xv = longint'(x);
        yv = longint'(y);
        if (s) begin
            if (x[11]) xv = xv - 4096;
            if (y[11]) yv = yv - 4096;
        end
        return 24'(xv * yv);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, count edges from accept to out_valid, then take the result.
    task automatic run_op(input int k, input logic [11:0] av, input logic [11:0] bv,
                          input logic sv, output int lat, output logic [23:0] p);
        a_in[k]      = av;
        b_in[k]      = bv;
        is_signed[k] = sv;
        in_valid[k]  = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        p = product[k];
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; is_signed[k] = 1'b0;
            a_in[k] = '0; b_in[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
                product[k] !== 24'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got rdy=%b vld=%b busy=%b prod=%h required 1 0 0 000000",
                         k, in_ready[k], out_valid[k], busy[k], product[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_max();
        int lat;
        logic [23:0] p;
        run_op(0, 12'hFFF, 12'hFFF, 1'b0, lat, p);
        n_checks++;
        if (p !== 24'hFFE001) begin
            n_fail++;
            $display("FAIL unsigned_max: got %h required ffe001", p);
        end
        n_checks++;
        if (lat !== 12) begin
            n_fail++;
            $display("FAIL unsigned_max_latency: got %0d required 12", lat);
        end
    endtask

    task automatic test_signed();
        logic [11:0] ta [3] = '{12'h800, 12'hFFF, 12'h007};
        logic [11:0] tb [3] = '{12'h800, 12'h005, 12'hFFD};
        logic [23:0] te [3] = '{24'h400000, 24'hFFFFFB, 24'hFFFFEB};
        int lat;
        logic [23:0] p;
        for (int i = 0; i < 3; i++) begin
            run_op(0, ta[i], tb[i], 1'b1, lat, p);
            n_checks++;
            if (p !== te[i]) begin
                n_fail++;
                $display("FAIL signed[%0d]: a=%h b=%h got %h required %h", i, ta[i], tb[i],
                         p, te[i]);
            end
        end
    endtask

    task automatic test_radix();
        int lat;
        logic [23:0] p;
        for (int k = 0; k < NI; k++) begin
            run_op(k, 12'd100, 12'd200, 1'b0, lat, p);
            n_checks++;
            if (p !== 24'd20000) begin
                n_fail++;
                $display("FAIL radix_r%0d: got %0d required 20000", k + 1, p);
            end
            n_checks++;
            if (lat !== 12 / (k + 1)) begin
                n_fail++;
                $display("FAIL radix_latency_r%0d: got %0d required %0d", k + 1, lat,
                         12 / (k + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_p;
        int wait_cyc;
        exp_p = ref_prod(12'h5A5, 12'h3C3, 1'b1);
        a_in[0] = 12'h5A5; b_in[0] = 12'h3C3; is_signed[0] = 1'b1;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        wait_cyc = 0;
        while (out_valid[0] !== 1'b1 && wait_cyc < 64) begin
            tick();
            wait_cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid[0]  = 1'($urandom_range(0, 1));
            a_in[0]      = 12'($urandom);
            b_in[0]      = 12'($urandom);
            is_signed[0] = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || product[0] !== exp_p) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got vld=%b rdy=%b prod=%h required 1 0 %h",
                         i, out_valid[0], in_ready[0], product[0], exp_p);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || product[0] !== exp_p) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b prod=%h required 0 1 %h",
                     out_valid[0], in_ready[0], product[0], exp_p);
        end
        tick();
        n_checks++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_new_op: got busy=%b required 0", busy[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [23:0] p;
        a_in[0] = 12'd1234; b_in[0] = 12'd567; is_signed[0] = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || product[0] !== 24'h0 || in_ready[0] !== 1'b1 ||
            busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got vld=%b prod=%h rdy=%b busy=%b required 0 0 1 0",
                     out_valid[0], product[0], in_ready[0], busy[0]);
        end
        #1;
        rst = 1'b0;
        tick();
        run_op(0, 12'd1234, 12'd567, 1'b0, lat, p);
        n_checks++;
        if (p !== ref_prod(12'd1234, 12'd567, 1'b0) || lat !== 12) begin
            n_fail++;
            $display("FAIL after_reset_op: got prod=%h lat=%0d required %h 12", p, lat,
                     ref_prod(12'd1234, 12'd567, 1'b0));
        end
    endtask

    task automatic test_random_stream();
        int ks [3] = '{0, 1, 3};
        for (int j = 0; j < 3; j++) begin
            int k = ks[j];
            logic [23:0] expq[$];
            int done = 0;
            int accepted = 0;
            int cyc = 0;
            while (done < 667 && cyc < 30000) begin
                a_in[k]      = 12'($urandom);
                b_in[k]      = 12'($urandom);
                is_signed[k] = 1'($urandom_range(0, 1));
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 3) != 0);
                if (in_valid[k] && in_ready[k] === 1'b1 && accepted < 667) begin
                    expq.push_back(ref_prod(a_in[k], b_in[k], is_signed[k]));
                    accepted++;
                end else if (accepted >= 667) begin
                    in_valid[k] = 1'b0;
                end
                if (out_valid[k] === 1'b1 && out_ready[k]) begin
                    n_checks++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL random_r%0d spurious: got prod=%h with no op pending",
                                 k + 1, product[k]);
                    end else begin
                        logic [23:0] e;
                        e = expq.pop_front();
                        if (product[k] !== e) begin
                            n_fail++;
                            $display("FAIL random_r%0d op %0d: got %h required %h", k + 1,
                                     done, product[k], e);
                        end
                    end
                    done++;
                end
                tick();
                cyc++;
            end
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            n_checks++;
            if (done !== 667) begin
                n_fail++;
                $display("FAIL random_r%0d timeout: got %0d results required 667", k + 1, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_radix();
        test_backpressure();
        test_reset_mid_run();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
